stamp_pool_rr: RTL and testbench

//   Parametrised successor to the fixed 5-unit OR-merge stamp pool. Collects per-slot stamp/take

---
 rtl/stamp_pool_rr.sv | 144 ++++++++++++++
 tb/tb_stamp_pool_rr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stamp_pool_rr.sv
// rtl/stamp_pool_rr.sv - per-slot round-robin stamp/take arbiter feeding the conveyor
//
// Purpose:
//   NUM_UNITS execution units post stamp/take requests per conveyor slot.
//   Each slot is arbitrated independently by round-robin. The winner gets a
//   combinational grant, and its data is registered onto the conveyor one cycle later.
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous active-low reset
//   conveyor_stop       conveyor stalled: no grants, all state frozen
//   unit_stamp_flat     stamp data, unit u slot s at [(u*NUM_SLOTS+s)*STAMP_W +: STAMP_W]
//   unit_stamp_in       stamp valid, bit u*NUM_SLOTS+s
//   unit_take_flat      take data, unit u slot s at [(u*NUM_SLOTS+s)*TAKE_W +: TAKE_W]
//   unit_take_in        take valid, bit u*NUM_SLOTS+s
//   unit_grant          one-cycle acceptance, bit u*NUM_SLOTS+s (combinational)
//   conveyor_stamp_flat registered winning stamp per slot
//   conveyor_stamp_in   registered stamp valid per slot
//   conveyor_take_flat  registered winning take per slot
//   conveyor_take_in    registered take valid per slot
//   conflict_cnt        saturating count of contended slot-cycles
module stamp_pool_rr #(
  parameter int NUM_UNITS = 5,
  parameter int NUM_SLOTS = 8,
  parameter int STAMP_W   = 3,
  parameter int TAKE_W    = 5,
  parameter int CNT_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 conveyor_stop,
  input  logic [NUM_UNITS*NUM_SLOTS*STAMP_W-1:0] unit_stamp_flat,
  input  logic [NUM_UNITS*NUM_SLOTS-1:0]         unit_stamp_in,
  input  logic [NUM_UNITS*NUM_SLOTS*TAKE_W-1:0]  unit_take_flat,
  input  logic [NUM_UNITS*NUM_SLOTS-1:0]         unit_take_in,
  output logic [NUM_UNITS*NUM_SLOTS-1:0]         unit_grant,
  output logic [NUM_SLOTS*STAMP_W-1:0]           conveyor_stamp_flat,
  output logic [NUM_SLOTS-1:0]                   conveyor_stamp_in,
  output logic [NUM_SLOTS*TAKE_W-1:0]            conveyor_take_flat,
  output logic [NUM_SLOTS-1:0]                   conveyor_take_in,
  output logic [CNT_W-1:0]                       conflict_cnt
);
  localparam int PTR_W = $clog2(NUM_UNITS);
  localparam int NREQ  = NUM_UNITS * NUM_SLOTS;
  // Wide enough to hold the counter plus one cycle's worth of contended slots.
  localparam int SUM_W = CNT_W + $clog2(NUM_SLOTS + 1);

  logic [NREQ-1:0]            req;
  logic                       active;
  logic [PTR_W-1:0]           rr_ptr [NUM_SLOTS];
  logic [PTR_W-1:0]           win    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]       hit;
  logic [NUM_SLOTS-1:0]       contended;
  logic [NUM_SLOTS-1:0]       nxt_stamp_in;
  logic [NUM_SLOTS-1:0]       nxt_take_in;
  logic [NUM_SLOTS*STAMP_W-1:0] nxt_stamp_flat;
  logic [NUM_SLOTS*TAKE_W-1:0]  nxt_take_flat;
  logic [SUM_W-1:0]           n_cont;
  logic [SUM_W-1:0]           cnt_sum;
  logic [CNT_W-1:0]           cnt_next;

  assign req    = unit_stamp_in | unit_take_in;
  assign active = reset & ~conveyor_stop;

  // Per slot: first requester scanning upward from rr_ptr, wrapping modulo NUM_UNITS.
  always_comb begin
    int idx;
    int nreq;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      hit[s]       = 1'b0;
      win[s]       = '0;
      contended[s] = 1'b0;
      nreq         = 0;
      for (int k = 0; k < NUM_UNITS; k++) begin
        idx = int'(rr_ptr[s]) + k;
        if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
        if (!hit[s] && req[idx*NUM_SLOTS+s]) begin
          hit[s] = 1'b1;
          win[s] = PTR_W'(idx);
        end
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (req[u*NUM_SLOTS+s]) nreq = nreq + 1;
      end
      contended[s] = (nreq >= 2);
    end
  end

  always_comb begin
    unit_grant = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        unit_grant[u*NUM_SLOTS+s] = active && hit[s] && (win[s] == PTR_W'(u));
      end
    end
  end

  // Winner's fields, each valid copied individually; an invalid field carries zero data.
  always_comb begin
    int w;
    nxt_stamp_in   = '0;
    nxt_take_in    = '0;
    nxt_stamp_flat = '0;
    nxt_take_flat  = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      w = int'(win[s]) * NUM_SLOTS + s;
      nxt_stamp_in[s] = hit[s] & unit_stamp_in[w];
      nxt_take_in[s]  = hit[s] & unit_take_in[w];
      if (nxt_stamp_in[s]) nxt_stamp_flat[s*STAMP_W +: STAMP_W] = unit_stamp_flat[w*STAMP_W +: STAMP_W];
      if (nxt_take_in[s])  nxt_take_flat[s*TAKE_W +: TAKE_W]    = unit_take_flat[w*TAKE_W +: TAKE_W];
    end
  end

  always_comb begin
    n_cont = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (contended[s]) n_cont = n_cont + SUM_W'(1);
    end
    cnt_sum  = SUM_W'(conflict_cnt) + n_cont;
    cnt_next = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conveyor_stamp_flat <= '0;
      conveyor_stamp_in   <= '0;
      conveyor_take_flat  <= '0;
      conveyor_take_in    <= '0;
      conflict_cnt        <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) rr_ptr[s] <= '0;
    end else if (!conveyor_stop) begin
      conveyor_stamp_flat <= nxt_stamp_flat;
      conveyor_stamp_in   <= nxt_stamp_in;
      conveyor_take_flat  <= nxt_take_flat;
      conveyor_take_in    <= nxt_take_in;
      conflict_cnt        <= cnt_next;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (hit[s]) begin
          rr_ptr[s] <= (win[s] == PTR_W'(NUM_UNITS - 1)) ? '0 : win[s] + PTR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_stamp_pool_rr.sv
// tb/tb_stamp_pool_rr.sv - self-checking bench for stamp_pool_rr
module tb_stamp_pool_rr;
  logic         clk;
  logic         rst;
  logic         stop;
  logic [119:0] usf;
  logic [39:0]  usi;
  logic [199:0] utf;
  logic [39:0]  uti;
  logic [39:0]  ug;
  logic [23:0]  csf;
  logic [7:0]   csi;
  logic [39:0]  ctf;
  logic [7:0]   cti;
  logic [3:0]   cnt;

  int n_tests = 0;
  int n_fail  = 0;

  stamp_pool_rr #(
    .NUM_UNITS(5), .NUM_SLOTS(8), .STAMP_W(3), .TAKE_W(5), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(rst),
    .conveyor_stop(stop),
    .unit_stamp_flat(usf),
    .unit_stamp_in(usi),
    .unit_take_flat(utf),
    .unit_take_in(uti),
    .unit_grant(ug),
    .conveyor_stamp_flat(csf),
    .conveyor_stamp_in(csi),
    .conveyor_take_flat(ctf),
    .conveyor_take_in(cti),
    .conflict_cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] sv;
    logic [39:0] tv;
    logic        stop;
    logic [39:0] g;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [15];

  logic [7:0]  e_si;
  logic [7:0]  e_ti;
  logic [23:0] e_sd;
  logic [39:0] e_td;

  function automatic logic [39:0] m(input int u, input int s);
    logic [39:0] r;
    r = '0;
    r[u*8+s] = 1'b1;
    return r;
  endfunction

  function automatic logic [2:0] pstamp(input int u, input int s);
    return 3'(u*3 + s + 1);
  endfunction

  function automatic logic [4:0] ptake(input int u, input int s);
    return 5'(u*7 + s*3 + 1);
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int u = 0; u < 5; u++) begin
      for (int s = 0; s < 8; s++) begin
        usf[(u*8+s)*3 +: 3] = pstamp(u, s);
        utf[(u*8+s)*5 +: 5] = ptake(u, s);
      end
    end
  endtask

  task automatic do_reset();
    usi = '0;
    uti = '0;
    stop = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_stamp_in"}, csi, e_si);
    chk({tag, "_take_in"}, cti, e_ti);
    chk({tag, "_stamp_data"}, csf, e_sd);
    chk({tag, "_take_data"}, ctf, e_td);
  endtask

  logic [39:0] three;
  logic [39:0] five;
  logic [39:0] sat_req;

  initial begin
    rst = 1'b0; stop = 1'b0; usf = '0; usi = '0; utf = '0; uti = '0;
    #3;
    chk("reset_grant", ug, 40'h0);
    chk("reset_stamp_in", csi, 8'h0);
    chk("reset_take_in", cti, 8'h0);
    chk("reset_cnt", cnt, 4'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    three = m(0,0) | m(1,0) | m(4,0);
    five  = m(0,0) | m(1,1) | m(2,2) | m(3,3) | m(4,4);
    tbl[0]  = '{40'h0, 40'h0, 1'b0, 40'h0, 4'd0};
    tbl[1]  = '{five, five, 1'b0, five, 4'd0};
    tbl[2]  = '{three, three, 1'b0, m(1,0), 4'd1};
    tbl[3]  = '{m(0,0)|m(4,0), m(0,0)|m(4,0), 1'b0, m(4,0), 4'd2};
    tbl[4]  = '{m(0,0), m(0,0), 1'b0, m(0,0), 4'd2};
    tbl[5]  = '{three, three, 1'b0, m(1,0), 4'd3};
    tbl[6]  = '{three, three, 1'b0, m(4,0), 4'd4};
    tbl[7]  = '{three, three, 1'b0, m(0,0), 4'd5};
    tbl[8]  = '{three, three, 1'b0, m(1,0), 4'd6};
    tbl[9]  = '{three, three, 1'b1, 40'h0, 4'd6};
    tbl[10] = '{three, three, 1'b1, 40'h0, 4'd6};
    tbl[11] = '{three, three, 1'b1, 40'h0, 4'd6};
    tbl[12] = '{three, three, 1'b0, m(4,0), 4'd7};
    tbl[13] = '{m(2,3)|m(3,3), m(0,6)|m(1,6), 1'b0, m(2,3)|m(0,6), 4'd9};
    tbl[14] = '{40'h0, 40'h0, 1'b0, 40'h0, 4'd9};

    fill_pattern();
    e_si = '0; e_ti = '0; e_sd = '0; e_td = '0;
    for (int i = 0; i < 15; i++) begin
      usi  = tbl[i].sv;
      uti  = tbl[i].tv;
      stop = tbl[i].stop;
      #3;
      chk($sformatf("v%0d_grant", i), ug, tbl[i].g);
      if (!tbl[i].stop) begin
        e_si = '0; e_ti = '0; e_sd = '0; e_td = '0;
        for (int s = 0; s < 8; s++) begin
          for (int u = 0; u < 5; u++) begin
            if (tbl[i].g[u*8+s]) begin
              e_si[s] = tbl[i].sv[u*8+s];
              e_ti[s] = tbl[i].tv[u*8+s];
              if (e_si[s]) e_sd[s*3 +: 3] = pstamp(u, s);
              if (e_ti[s]) e_td[s*5 +: 5] = ptake(u, s);
            end
          end
        end
      end
      @(posedge clk);
      #1;
      chk_outputs($sformatf("v%0d", i));
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].cnt);
    end
    stop = 1'b0;

    // Single request with explicit data: unit 2, slot 5.
    do_reset();
    usf = '0; utf = '0;
    usf[(2*8+5)*3 +: 3] = 3'b101;
    utf[(2*8+5)*5 +: 5] = 5'd17;
    usi = m(2,5);
    uti = m(2,5);
    #3;
    chk("single_grant", ug, m(2,5));
    @(posedge clk);
    #1;
    e_si = 8'h20; e_ti = 8'h20;
    e_sd = 24'h0; e_sd[15 +: 3] = 3'd5;
    e_td = 40'h0; e_td[25 +: 5] = 5'd17;
    chk_outputs("single");
    usi = '0; uti = '0;
    @(posedge clk);
    #1;
    e_si = '0; e_ti = '0; e_sd = '0; e_td = '0;
    chk_outputs("idle_after_single");

    // Reset in the middle of traffic, then lowest-index requester wins.
    fill_pattern();
    usi = m(0,0) | m(1,0);
    uti = m(0,0) | m(1,0);
    #3;
    chk("pre_reset_grant", ug, m(0,0));
    @(posedge clk);
    #1;
    chk("pre_reset_cnt", cnt, 4'd1);
    #1 rst = 1'b0;
    #1;
    e_si = '0; e_ti = '0; e_sd = '0; e_td = '0;
    chk_outputs("async_reset");
    chk("async_reset_cnt", cnt, 4'd0);
    chk("async_reset_grant", ug, 40'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    #3;
    chk("post_reset_grant", ug, m(0,0));
    @(posedge clk);
    #1;

    // Saturation: all 8 slots contended by units 0 and 1.
    do_reset();
    sat_req = 40'h0000_00FFFF;
    usi = sat_req;
    uti = '0;
    @(posedge clk);
    #1;
    chk("sat_cycle1", cnt, 4'd8);
    @(posedge clk);
    #1;
    chk("sat_cycle2", cnt, 4'd15);
    @(posedge clk);
    #1;
    chk("sat_cycle3", cnt, 4'd15);
    usi = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
